tandem_axil_cmd_seq: RTL
========================

TANDEM_AXIL_CMD_SEQ -- requirements
Module: tandem_axil_cmd_seq

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, AXI-Lite/command address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width; STRB_WIDTH fixed at DATA_WIDTH/8.
REQ-003 SHALL have parameter TIMEOUT, default 1023, maximum wait cycles per AXI channel phase (1..65535).
REQ-004 SHALL have a single clock and an asynchronous, active-high reset, on the ports listed below.
REQ-005 axi_aclk  in  1  sole clock; all logic rising-edge.
REQ-006 axi_areset  in  1  asynchronous active-high reset.
REQ-007 cmd_valid  in  1  command request.
REQ-008 cmd_ready  out  1  command accepted when valid&ready.
REQ-009 cmd_write  in  1  1 = write, 0 = read.
REQ-010 cmd_addr  in  ADDR_WIDTH  target address.
REQ-011 cmd_wdata  in  DATA_WIDTH  write data (ignored for reads).
REQ-012 rsp_valid  out  1  one-cycle completion pulse, no backpressure.
REQ-013 rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and timeouts.
REQ-014 rsp_status  out  2  00 OKAY, 01 EXOKAY, 10 SLVERR/DECERR, 11 timeout.
REQ-015 m_axil_awaddr/awvalid/awready  out/out/in  ADDR_WIDTH/1/1  write-address channel.
REQ-016 m_axil_wdata/wstrb/wvalid/wready  out/out/out/in  DATA_WIDTH/STRB_WIDTH/1/1  write-data channel; wstrb all ones.
REQ-017 m_axil_bresp/bvalid/bready  in/in/out  2/1/1  write-response channel.
REQ-018 m_axil_araddr/arvalid/arready  out/out/in  ADDR_WIDTH/1/1  read-address channel.
REQ-019 m_axil_rdata/rresp/rvalid/rready  in/in/in/out  DATA_WIDTH/2/1/1  read-data channel; awprot/arprot not exposed, driven 3'b000 downstream.

Function
REQ-020 FSM states SHALL be IDLE, WREQ, WRESP, RREQ, RRESP; one transaction outstanding at a time.
REQ-021 cmd_ready SHALL be 1 only in IDLE; on accept, addr/data are registered, and the FSM goes to WREQ (cmd_write=1) or RREQ (cmd_write=0).
REQ-022 WREQ: awvalid and wvalid SHALL both assert the cycle after accept and each SHALL drop independently after its own handshake; move to WRESP once both have completed, in either order or together.
REQ-023 WRESP: bready=1; on bvalid, rsp_valid SHALL pulse the next cycle with rsp_status=bresp (10 for 10/11), then return to IDLE.
REQ-024 RREQ: arvalid=1 until arready, then RRESP with rready=1; on rvalid, rsp_valid SHALL pulse the next cycle with rsp_rdata=rdata and status from rresp.
REQ-025 A 16-bit wait counter SHALL clear on entering each non-IDLE state and on every handshake; if it reaches TIMEOUT without handshake, all valids SHALL drop, rsp_status=11 SHALL pulse, and the FSM SHALL return to IDLE.
REQ-026 In IDLE, bready and rready SHALL be 1 so stale responses after a timeout are drained and discarded with no rsp_valid.
REQ-027 Valid outputs SHALL not deassert before their handshake except on timeout; addr/data SHALL be stable while valid.
REQ-028 Minimum latency, accept to rsp_valid, SHALL be 3 cycles with zero-wait slave: accept N, valid N+1, response N+2, rsp_valid N+3.
REQ-029 A cmd_valid arriving while busy SHALL wait (cmd_ready=0), never be dropped or merged.

Reset
REQ-030 While axi_areset=1, the FSM SHALL be IDLE, all valids, rsp_valid, rsp_rdata, rsp_status, and the counter SHALL be 0; addresses/data SHALL be 0.
REQ-031 Reset asserted mid-transaction SHALL abort immediately with no rsp_valid; the first command after deassertion SHALL be accepted normally.

Verification
REQ-032 Write 0x10 = 0xA5A5A5A5, zero-wait slave, bresp=00 -> aw/w handshake at N+1, rsp_valid at N+3, status 00.
REQ-033 Read 0x04, arready delayed 5 cycles, rdata 0x12345678, rresp=00 -> arvalid held 5 cycles, rsp_rdata 0x12345678, status 00.
REQ-034 Write with wready 3 cycles before awready, then bresp=10 -> each valid drops after its own handshake, status 10.
REQ-035 TIMEOUT=8, read, arready never asserted -> arvalid drops after 8 wait cycles, rsp_status 11, late rvalid in IDLE consumed silently.
REQ-036 Reset pulse while in WRESP, then a new read -> no rsp_valid for the aborted write; the read completes with correct data.

Source files
------------

// File: rtl/tandem_axil_cmd_seq_if.sv
// AXI-Lite bus bundle between the command sequencer (master) and a slave.
// Protection fields are not carried; a wrapper ties awprot/arprot to 3'b000.
interface tandem_axil_cmd_seq_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic [ADDR_WIDTH-1:0] awaddr;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input  bresp, bvalid, output bready,
        output araddr, arvalid, input arready,
        input  rdata, rresp, rvalid, output rready
    );

    modport slave (
        input  awaddr, awvalid, output awready,
        input  wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input  araddr, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/tandem_axil_cmd_seq.sv
// Single-outstanding command sequencer: turns one read/write command at a
// time into an AXI-Lite transaction and reports a one-cycle completion pulse.
// Each channel phase is guarded by a wait counter that aborts with status 11.
module tandem_axil_cmd_seq #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 1023
) (
    input  logic                  axi_aclk,
    input  logic                  axi_areset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]            rsp_status,
    tandem_axil_cmd_seq_if.master m_axil
);
    // Counter value at which a phase with no handshake is abandoned, so a
    // valid is visible for exactly TIMEOUT cycles before it drops.
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WREQ  = 3'd1,
        WRESP = 3'd2,
        RREQ  = 3'd3,
        RRESP = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic                  awvalid_q, awvalid_d;
    logic                  wvalid_q, wvalid_d;
    logic                  arvalid_q, arvalid_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [15:0]           wait_q, wait_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [1:0]            rsp_status_q, rsp_status_d;

    logic aw_hs_s, w_hs_s, b_hs_s, ar_hs_s, r_hs_s;
    logic aw_done_s, w_done_s, expired_s;

    // SLVERR and DECERR both collapse to 10; 11 is reserved for timeout.
    function automatic logic [1:0] map_resp(input logic [1:0] resp);
        map_resp = resp[1] ? 2'b10 : resp;
    endfunction

    assign aw_hs_s   = awvalid_q & m_axil.awready;
    assign w_hs_s    = wvalid_q & m_axil.wready;
    assign b_hs_s    = (state_q == WRESP) & m_axil.bvalid;
    assign ar_hs_s   = arvalid_q & m_axil.arready;
    assign r_hs_s    = (state_q == RRESP) & m_axil.rvalid;
    assign aw_done_s = ~awvalid_q | aw_hs_s;
    assign w_done_s  = ~wvalid_q | w_hs_s;
    assign expired_s = (wait_q == WAIT_LAST);

    assign cmd_ready      = (state_q == IDLE);
    // Response channels stay ready in IDLE so stale beats after a timeout drain.
    assign m_axil.bready  = (state_q == IDLE) | (state_q == WRESP);
    assign m_axil.rready  = (state_q == IDLE) | (state_q == RRESP);
    assign m_axil.awaddr  = addr_q;
    assign m_axil.araddr  = addr_q;
    assign m_axil.wdata   = wdata_q;
    assign m_axil.wstrb   = '1;
    assign m_axil.awvalid = awvalid_q;
    assign m_axil.wvalid  = wvalid_q;
    assign m_axil.arvalid = arvalid_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_rdata      = rsp_rdata_q;
    assign rsp_status     = rsp_status_q;

    // Next-state, channel valids, wait counter and completion response.
    always_comb begin
        state_d      = state_q;
        awvalid_d    = awvalid_q;
        wvalid_d     = wvalid_q;
        arvalid_d    = arvalid_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wait_d       = wait_q + 16'd1;
        rsp_valid_d  = 1'b0;
        rsp_rdata_d  = '0;
        rsp_status_d = 2'b00;
        case (state_q)
            IDLE: begin
                wait_d = 16'd0;
                if (cmd_valid) begin
                    addr_d = cmd_addr;
                    if (cmd_write) begin
                        wdata_d   = cmd_wdata;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WREQ;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = RREQ;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WREQ: begin
                if (aw_hs_s) awvalid_d = 1'b0; else awvalid_d = awvalid_q;
                if (w_hs_s)  wvalid_d  = 1'b0; else wvalid_d  = wvalid_q;
                if (aw_hs_s | w_hs_s) begin
                    wait_d = 16'd0;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
                if (aw_done_s & w_done_s) begin
                    state_d = WRESP;
                end else if (!(aw_hs_s | w_hs_s) && expired_s) begin
                    awvalid_d    = 1'b0;
                    wvalid_d     = 1'b0;
                    rsp_valid_d  = 1'b1;
                    rsp_status_d = 2'b11;
                    state_d      = IDLE;
                end else begin
                    state_d = WREQ;
                end
            end
            WRESP: begin
                if (b_hs_s) begin
                    rsp_valid_d  = 1'b1;
                    rsp_status_d = map_resp(m_axil.bresp);
                    state_d      = IDLE;
                end else if (expired_s) begin
                    rsp_valid_d  = 1'b1;
                    rsp_status_d = 2'b11;
                    state_d      = IDLE;
                end else begin
                    state_d = WRESP;
                end
            end
            RREQ: begin
                if (ar_hs_s) begin
                    arvalid_d = 1'b0;
                    wait_d    = 16'd0;
                    state_d   = RRESP;
                end else if (expired_s) begin
                    arvalid_d    = 1'b0;
                    rsp_valid_d  = 1'b1;
                    rsp_status_d = 2'b11;
                    state_d      = IDLE;
                end else begin
                    state_d = RREQ;
                end
            end
            RRESP: begin
                if (r_hs_s) begin
                    rsp_valid_d  = 1'b1;
                    rsp_rdata_d  = m_axil.rdata;
                    rsp_status_d = map_resp(m_axil.rresp);
                    state_d      = IDLE;
                end else if (expired_s) begin
                    rsp_valid_d  = 1'b1;
                    rsp_status_d = 2'b11;
                    state_d      = IDLE;
                end else begin
                    state_d = RRESP;
                end
            end
            default: begin
                awvalid_d = 1'b0;
                wvalid_d  = 1'b0;
                arvalid_d = 1'b0;
                wait_d    = 16'd0;
                state_d   = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any transaction silently.
    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            state_q      <= IDLE;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            arvalid_q    <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wait_q       <= 16'd0;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= '0;
            rsp_status_q <= 2'b00;
        end else begin
            state_q      <= state_d;
            awvalid_q    <= awvalid_d;
            wvalid_q     <= wvalid_d;
            arvalid_q    <= arvalid_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wait_q       <= wait_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_status_q <= rsp_status_d;
        end
    end
endmodule
